tiny_rv_fetch: RTL and testbench

Instruction fetch stage of the tiny_rv core, directly upstream of decode. Owns the PC and issues one-outstanding-request reads to an instruction memory port with a req/gnt + rvalid handshake. Presents fetch_pc/fetch_inst/fetch_valid to decode. Honours pipeline stall via a one-entry holding buffer, and flush/redirect from execute, dropping any in-flight response.

---
 rtl/rv_pkg.sv | 17 +
 rtl/tiny_rv_fetch.sv | 117 +++++++++++
 tb/tb_tiny_rv_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the tiny_rv core: word type, canonical NOP encoding
// and the fetch-stage state enumeration.
package rv_pkg;

   typedef logic [31:0] word_t;

   localparam word_t RV_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      FETCH_IDLE  = 3'd0,
      FETCH_REQ   = 3'd1,
      FETCH_WAIT  = 3'd2,
      FETCH_HOLD  = 3'd3,
      FETCH_DRAIN = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/tiny_rv_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a
// time, buffers one response under stall and discards responses killed by flush.
module tiny_rv_fetch
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pipe_stall,
   input  logic        i_pipe_flush,
   input  logic [31:0] i_flush_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_inst,
   output logic        fetch_valid
);

   localparam logic [2:0] S_IDLE  = FETCH_IDLE;
   localparam logic [2:0] S_REQ   = FETCH_REQ;
   localparam logic [2:0] S_WAIT  = FETCH_WAIT;
   localparam logic [2:0] S_HOLD  = FETCH_HOLD;
   localparam logic [2:0] S_DRAIN = FETCH_DRAIN;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   word_t       pc;
   word_t       pc_nxt;
   word_t       req_pc;
   word_t       buf_pc;
   word_t       buf_inst;
   logic        load_rsp;
   logic        load_buf;
   logic        capture_buf;

   // A flush overrides the normal transition; any grant or response that is
   // still outstanding when the flush hits must be drained before refetching.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         S_IDLE:  state_nxt = S_REQ;
         S_REQ:   if (i_imem_gnt) state_nxt = S_WAIT;
         S_WAIT:  if (i_imem_rvalid) begin
                     pc_nxt    = req_pc + 32'd4;
                     state_nxt = i_pipe_stall ? S_HOLD : S_REQ;
                  end
         S_HOLD:  if (!i_pipe_stall) state_nxt = S_REQ;
         S_DRAIN: if (i_imem_rvalid) state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase
      if (i_pipe_flush) begin
         pc_nxt = {i_flush_pc[31:2], 2'b00};
         case (state)
            S_REQ:           state_nxt = i_imem_gnt ? S_DRAIN : S_REQ;
            S_WAIT, S_DRAIN: state_nxt = i_imem_rvalid ? S_REQ : S_DRAIN;
            default:         state_nxt = S_REQ;
         endcase
      end
   end

   assign load_rsp    = (state == S_WAIT) && i_imem_rvalid && !i_pipe_flush && !i_pipe_stall;
   assign load_buf    = (state == S_HOLD) && !i_pipe_flush && !i_pipe_stall;
   assign capture_buf = (state == S_WAIT) && i_imem_rvalid && !i_pipe_flush && i_pipe_stall;

   // The request port is registered from the next state so req/addr are glitch
   // free and stay stable for the whole REQ period.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         req_pc      <= '0;
         buf_pc      <= '0;
         buf_inst    <= RV_NOP;
         o_imem_req  <= 1'b0;
         o_imem_addr <= '0;
         fetch_pc    <= '0;
         fetch_inst  <= RV_NOP;
         fetch_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         o_imem_req <= (state_nxt == S_REQ);
         if (state_nxt == S_REQ) o_imem_addr <= pc_nxt;
         if ((state == S_REQ) && i_imem_gnt) req_pc <= o_imem_addr;

         if (capture_buf) begin
            buf_pc   <= req_pc;
            buf_inst <= i_imem_rdata;
         end else if (i_pipe_flush || load_buf) begin
            buf_pc   <= '0;
            buf_inst <= RV_NOP;
         end

         if (i_pipe_flush || !i_pipe_stall) begin
            if (load_rsp) begin
               fetch_pc    <= req_pc;
               fetch_inst  <= i_imem_rdata;
               fetch_valid <= 1'b1;
            end else if (load_buf) begin
               fetch_pc    <= buf_pc;
               fetch_inst  <= buf_inst;
               fetch_valid <= 1'b1;
            end else begin
               fetch_pc    <= '0;
               fetch_inst  <= RV_NOP;
               fetch_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_tiny_rv_fetch.sv
// Randomized bench for tiny_rv_fetch: a memory model answers requests, and a
// monitor checks the consumed instruction stream against program order.
module tb_tiny_rv_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_pipe_stall = 1'b0;
   logic        i_pipe_flush = 1'b0;
   logic [31:0] i_flush_pc = '0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        fetch_valid;

   tiny_rv_fetch dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_pipe_stall (i_pipe_stall),
      .i_pipe_flush (i_pipe_flush),
      .i_flush_pc   (i_flush_pc),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_gnt   (i_imem_gnt),
      .i_imem_rvalid(i_imem_rvalid),
      .i_imem_rdata (i_imem_rdata),
      .fetch_pc     (fetch_pc),
      .fetch_inst   (fetch_inst),
      .fetch_valid  (fetch_valid)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // program-order expectation: PCs decode must see next, refilled on redirect
   logic [31:0] exp_q[$];
   logic [31:0] next_push = 32'h0;

   // memory model state
   logic        mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_dly  = 0;
   logic        gnt_given = 1'b0;
   logic [31:0] addr_given = '0;
   logic        rv_given = 1'b0;

   // stimulus knobs
   int   gnt_pct = 100;
   int   max_dly = 0;
   int   stall_pct = 0;
   int   flush_pct = 0;
   logic zero_wait = 1'b0;
   logic do_reset = 1'b1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h0000_00A5;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 6) begin
         exp_q.push_back(next_push);
         next_push = next_push + 32'd4;
      end
   endtask

   task automatic apply_stimulus();
      logic [31:0] tgt;
      @(negedge i_clk);
      if (rv_given) mem_pend = 1'b0;
      if (gnt_given) begin
         mem_pend = 1'b1;
         mem_addr = addr_given;
         mem_dly  = $urandom_range(0, max_dly);
      end
      if (do_reset) begin
         i_reset       = 1'b1;
         i_imem_gnt    = 1'b0;
         i_imem_rvalid = 1'b0;
         i_pipe_stall  = 1'b0;
         i_pipe_flush  = 1'b0;
         mem_pend      = 1'b0;
         gnt_given     = 1'b0;
         rv_given      = 1'b0;
         exp_q.delete();
         next_push = 32'h0;
         top_up();
         return;
      end
      i_reset = 1'b0;
      i_imem_rvalid = mem_pend && (mem_dly == 0);
      if (mem_pend && mem_dly != 0) mem_dly--;
      i_imem_rdata = i_imem_rvalid ? mem_word(mem_addr) : $urandom;
      i_imem_gnt   = ($urandom_range(0, 99) < gnt_pct);
      i_pipe_stall = ($urandom_range(0, 99) < stall_pct);
      i_pipe_flush = ($urandom_range(0, 99) < flush_pct);
      if (i_pipe_flush) begin
         case ($urandom_range(0, 3))
            0:       tgt = 32'h0000_0102;
            1:       tgt = 32'hFFFF_FFF4 | 32'($urandom_range(0, 3));
            2:       tgt = $urandom;
            default: tgt = 32'($urandom_range(0, 255));
         endcase
         i_flush_pc = tgt;
         exp_q.delete();
         next_push = {tgt[31:2], 2'b00};
      end else begin
         i_flush_pc = $urandom;
      end
      top_up();
      gnt_given  = o_imem_req && i_imem_gnt;
      addr_given = o_imem_addr;
      rv_given   = i_imem_rvalid;
   endtask

   // Monitor: samples mid-cycle, after the driver has set the inputs that the
   // next rising edge will see.
   initial begin : monitor
      logic        prev_reset = 1'b0, prev_flush = 1'b0, prev_stall = 1'b0;
      logic        prev_req = 1'b0, prev_gnt = 1'b0, prev_valid = 1'b0;
      logic [31:0] prev_addr = '0, prev_pc = '0, prev_inst = '0;
      logic        held = 1'b0, drain = 1'b0, have_last = 1'b0;
      logic [31:0] exp_pc;
      int          cyc = 0, last_cons = 0, idle_cnt = 0;
      forever begin
         @(negedge i_clk);
         #2;
         cyc++;
         if (prev_reset && !i_reset) begin
            check_output("rst_req",   {31'b0, o_imem_req}, 32'h0);
            check_output("rst_addr",  o_imem_addr, 32'h0);
            check_output("rst_valid", {31'b0, fetch_valid}, 32'h0);
            check_output("rst_inst",  fetch_inst, NOP);
            check_output("rst_pc",    fetch_pc, 32'h0);
         end
         if (fetch_valid === 1'b0) begin
            check_output("bubble_inst", fetch_inst, NOP);
            check_output("bubble_pc",   fetch_pc, 32'h0);
         end
         if (prev_flush && !prev_reset)
            check_output("flush_bubble", {31'b0, fetch_valid}, 32'h0);
         if (prev_stall && !prev_flush && !prev_reset) begin
            check_output("stall_hold_valid", {31'b0, fetch_valid}, {31'b0, prev_valid});
            check_output("stall_hold_pc",    fetch_pc, prev_pc);
            check_output("stall_hold_inst",  fetch_inst, prev_inst);
         end
         if (held && !prev_reset)
            check_output("hold_no_req", {31'b0, o_imem_req}, 32'h0);
         if (prev_req && !prev_gnt && !prev_flush && !prev_reset) begin
            check_output("req_stable",  {31'b0, o_imem_req}, 32'h1);
            check_output("addr_stable", o_imem_addr, prev_addr);
         end

         if (i_reset) begin
            have_last = 1'b0;
            idle_cnt  = 0;
         end else if (!i_pipe_flush && !i_pipe_stall && fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_output("queue_empty", fetch_pc, 32'hXXXX_XXXX);
            end else begin
               exp_pc = exp_q.pop_front();
               check_output("inst_pc",   fetch_pc, exp_pc);
               check_output("inst_word", fetch_inst, mem_word(exp_pc));
            end
            if (zero_wait && have_last)
               check_output("zero_wait_rate", 32'(cyc - last_cons), 32'd2);
            have_last = 1'b1;
            last_cons = cyc;
            idle_cnt  = 0;
         end else begin
            idle_cnt++;
            if (idle_cnt > 400) begin
               check_output("progress_timeout", 32'(idle_cnt), 32'd0);
               idle_cnt = 0;
            end
         end

         if (i_reset) begin
            held  = 1'b0;
            drain = 1'b0;
         end else if (i_pipe_flush) begin
            held  = 1'b0;
            drain = (mem_pend && !i_imem_rvalid) || (o_imem_req && i_imem_gnt);
         end else begin
            if (!i_pipe_stall) held = 1'b0;
            else if (i_imem_rvalid && !drain) held = 1'b1;
            if (i_imem_rvalid) drain = 1'b0;
         end

         prev_reset = i_reset;
         prev_flush = i_pipe_flush;
         prev_stall = i_pipe_stall;
         prev_req   = o_imem_req;
         prev_gnt   = i_imem_gnt;
         prev_addr  = o_imem_addr;
         prev_valid = fetch_valid;
         prev_pc    = fetch_pc;
         prev_inst  = fetch_inst;
      end
   end

   task automatic run_phase(input int cycles, input int g, input int d, input int s,
                            input int f, input logic zw);
      gnt_pct = g; max_dly = d; stall_pct = s; flush_pct = f; zero_wait = zw;
      for (int i = 0; i < cycles; i++) apply_stimulus();
   endtask

   initial begin : sequencer
      do_reset = 1'b1;
      for (int i = 0; i < 3; i++) apply_stimulus();
      do_reset = 1'b0;
      run_phase(40,  100, 0, 0,  0,  1'b1);
      run_phase(200, 40,  3, 0,  0,  1'b0);
      run_phase(300, 70,  2, 40, 0,  1'b0);
      run_phase(600, 70,  2, 30, 12, 1'b0);
      run_phase(7,   60,  2, 20, 0,  1'b0);
      do_reset = 1'b1;
      for (int i = 0; i < 2; i++) apply_stimulus();
      do_reset = 1'b0;
      run_phase(30,  100, 0, 0,  0,  1'b1);
      run_phase(400, 60,  3, 35, 15, 1'b0);
      gnt_pct = 100; max_dly = 0; stall_pct = 0; flush_pct = 0;
      for (int i = 0; i < 6; i++) apply_stimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
